// File: rtl/reram_op_sequencer.sv
// Operation sequencer for a 1T1R RRAM crossbar: READ, SET, RESET and FORM
// with a write-verify-retry loop, driving line selects, rail codes, pulse and
// sense-amp enables. All outputs are registered, decoded from next-state values.
module reram_op_sequencer #(
  parameter int unsigned ROWS      = 16,
  parameter int unsigned COLS      = 16,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned READ_CYC  = 4,
  parameter int unsigned SET_CYC   = 8,
  parameter int unsigned RESET_CYC = 8,
  parameter int unsigned FORM_CYC  = 200,
  parameter int unsigned DISCH_CYC = 2,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned IW = $clog2(ROWS),
  localparam int unsigned CW = $clog2(COLS)
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [IW-1:0]   cmd_row,
  input  logic [CW-1:0]   cmd_col,
  input  logic            sa_out,
  output logic [ROWS-1:0] wl_sel,
  output logic [COLS-1:0] bl_sel,
  output logic [COLS-1:0] sl_sel,
  output logic [1:0]      wl_vsel,
  output logic [1:0]      bl_vsel,
  output logic [1:0]      sl_vsel,
  output logic            pulse_en,
  output logic            sa_en,
  output logic            busy,
  output logic            rsp_valid,
  output logic            rsp_data,
  output logic            rsp_fail,
  output logic [3:0]      rsp_tries
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_DISCH = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_SET   = 2'd1,
    OP_RESET = 2'd2,
    OP_FORM  = 2'd3
  } op_e;

  typedef enum logic {
    K_WR = 1'b0,
    K_RD = 1'b1
  } kind_e;

  // Rail codes: 0=V1 1=V2 2=V3 3=V4 (ground)
  localparam logic [1:0] V1 = 2'd0;
  localparam logic [1:0] V2 = 2'd1;
  localparam logic [1:0] V4 = 2'd3;

  state_e            state, state_n;
  kind_e             kind, kind_n;
  op_e               op, op_n;
  logic [IW-1:0]     row, row_n;
  logic [CW-1:0]     col, col_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [3:0]        tries, tries_n;
  logic              sample, sample_n;
  logic              fail, fail_n;
  logic              out_of_range;
  logic              expect_lrs;
  logic              sel_active;
  logic [5:0]        rails;

  // Pulse width (minus one) of the op's own write pulse
  function automatic logic [CNT_W-1:0] wr_len(input op_e o);
    case (o)
      OP_SET:   wr_len = CNT_W'(SET_CYC - 1);
      OP_RESET: wr_len = CNT_W'(RESET_CYC - 1);
      OP_FORM:  wr_len = CNT_W'(FORM_CYC - 1);
      default:  wr_len = CNT_W'(READ_CYC - 1);
    endcase
  endfunction

  // Rail table {wl, bl, sl} for the active phase
  function automatic logic [5:0] rail_codes(input op_e o, input kind_e k);
    if (k == K_RD || o == OP_READ) rail_codes = {V2, V2, V4};
    else if (o == OP_RESET)        rail_codes = {V1, V4, V1};
    else                           rail_codes = {V2, V1, V4};
  endfunction

  assign out_of_range = (32'(cmd_row) >= ROWS) || (32'(cmd_col) >= COLS);
  assign expect_lrs   = (op != OP_RESET);

  // Next-state and datapath updates
  always_comb begin
    state_n  = state;
    kind_n   = kind;
    op_n     = op;
    row_n    = row;
    col_n    = col;
    cnt_n    = cnt;
    tries_n  = tries;
    sample_n = sample;
    fail_n   = fail;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_n    = op_e'(cmd_op);
          row_n   = cmd_row;
          col_n   = cmd_col;
          tries_n = 4'd0;
          if (out_of_range) begin
            state_n = S_RESP;
            fail_n  = 1'b1;
          end else begin
            state_n = S_SETUP;
            kind_n  = (op_e'(cmd_op) == OP_READ) ? K_RD : K_WR;
            cnt_n   = CNT_W'(SETUP_CYC - 1);
            fail_n  = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_n = S_PULSE;
          if (kind == K_RD) begin
            cnt_n = CNT_W'(READ_CYC - 1);
          end else begin
            cnt_n   = wr_len(op);
            tries_n = tries + 4'd1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          if (kind == K_RD) sample_n = sa_out;
          state_n = S_DISCH;
          cnt_n   = CNT_W'(DISCH_CYC - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DISCH: begin
        if (cnt == '0) begin
          if (kind == K_WR) begin
            state_n = S_SETUP;
            kind_n  = K_RD;
            cnt_n   = CNT_W'(SETUP_CYC - 1);
          end else if (op == OP_READ || sample == expect_lrs) begin
            state_n = S_RESP;
            fail_n  = 1'b0;
          end else if (32'(tries) <= MAX_RETRY) begin
            state_n = S_SETUP;
            kind_n  = K_WR;
            cnt_n   = CNT_W'(SETUP_CYC - 1);
          end else begin
            state_n = S_RESP;
            fail_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign sel_active = (state_n == S_SETUP) || (state_n == S_PULSE);
  assign rails      = rail_codes(op_n, kind_n);

  // State register and registered output decode
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      kind      <= K_WR;
      op        <= OP_READ;
      row       <= '0;
      col       <= '0;
      cnt       <= '0;
      tries     <= '0;
      sample    <= 1'b0;
      fail      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      wl_sel    <= '0;
      bl_sel    <= '0;
      sl_sel    <= '0;
      wl_vsel   <= V4;
      bl_vsel   <= V4;
      sl_vsel   <= V4;
      pulse_en  <= 1'b0;
      sa_en     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      rsp_fail  <= 1'b0;
      rsp_tries <= '0;
    end else begin
      state     <= state_n;
      kind      <= kind_n;
      op        <= op_n;
      row       <= row_n;
      col       <= col_n;
      cnt       <= cnt_n;
      tries     <= tries_n;
      sample    <= sample_n;
      fail      <= fail_n;
      cmd_ready <= (state_n == S_IDLE);
      busy      <= (state_n != S_IDLE);
      wl_sel    <= sel_active ? (ROWS'(1) << row_n) : '0;
      bl_sel    <= sel_active ? (COLS'(1) << col_n) : '0;
      sl_sel    <= sel_active ? (COLS'(1) << col_n) : '0;
      wl_vsel   <= sel_active ? rails[5:4] : V4;
      bl_vsel   <= sel_active ? rails[3:2] : V4;
      sl_vsel   <= sel_active ? rails[1:0] : V4;
      pulse_en  <= (state_n == S_PULSE);
      sa_en     <= (state_n == S_PULSE) && (kind_n == K_RD);
      rsp_valid <= (state_n == S_RESP);
      if (state_n == S_RESP) begin
        rsp_data  <= sample_n;
        rsp_fail  <= fail_n;
        rsp_tries <= tries_n;
      end
    end
  end

endmodule

// File: tb/tb_reram_op_sequencer.sv
// Self-checking bench for reram_op_sequencer: directed scenarios plus a
// response scoreboard checking data, fail flag, try count and arrival cycle.
module tb_reram_op_sequencer;

  localparam int unsigned ROWS = 12;
  localparam int unsigned COLS = 12;
  localparam int unsigned IW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);

  logic            clk = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [IW-1:0]   cmd_row = '0;
  logic [CW-1:0]   cmd_col = '0;
  logic            sa_out = 1'b1;
  logic [ROWS-1:0] wl_sel;
  logic [COLS-1:0] bl_sel;
  logic [COLS-1:0] sl_sel;
  logic [1:0]      wl_vsel, bl_vsel, sl_vsel;
  logic            pulse_en, sa_en, busy;
  logic            rsp_valid, rsp_data, rsp_fail;
  logic [3:0]      rsp_tries;

  int vectors = 0;
  int errors  = 0;
  int edge_cnt = 0;

  typedef struct {
    logic       data;
    logic       fail;
    logic [3:0] tries;
    int         due;
  } exp_t;

  exp_t sb[$];

  reram_op_sequencer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_row  (cmd_row),
    .cmd_col  (cmd_col),
    .sa_out   (sa_out),
    .wl_sel   (wl_sel),
    .bl_sel   (bl_sel),
    .sl_sel   (sl_sel),
    .wl_vsel  (wl_vsel),
    .bl_vsel  (bl_vsel),
    .sl_vsel  (sl_vsel),
    .pulse_en (pulse_en),
    .sa_en    (sa_en),
    .busy     (busy),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_fail (rsp_fail),
    .rsp_tries(rsp_tries)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Response scoreboard and per-cycle select sanity
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!wb_rst_i) begin
      if (rsp_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid at edge %0d with empty scoreboard", edge_cnt);
        end else begin
          e = sb.pop_front();
          if (rsp_data !== e.data || rsp_fail !== e.fail || rsp_tries !== e.tries || edge_cnt != e.due) begin
            errors++;
            $display("FAIL rsp: got data=%b fail=%b tries=%0d edge=%0d, want data=%b fail=%b tries=%0d edge=%0d",
                     rsp_data, rsp_fail, rsp_tries, edge_cnt, e.data, e.fail, e.tries, e.due);
          end
        end
      end
      vectors++;
      if ($countones(wl_sel) > 1 || $countones(bl_sel) > 1 || bl_sel !== sl_sel) begin
        errors++;
        $display("FAIL onehot: wl=%h bl=%h sl=%h, want at most one line each and bl==sl", wl_sel, bl_sel, sl_sel);
      end
    end
  end

  // Wait for cmd_ready, present a command, return the accept edge index
  task automatic issue(input logic [1:0] op, input logic [IW-1:0] r, input logic [CW-1:0] c,
                       input bit hold, output int acc);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      vectors++;
      errors++;
      $display("FAIL ready_timeout: cmd_ready=%b, want 1", cmd_ready);
    end
    cmd_op = op;
    cmd_row = r;
    cmd_col = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    acc = edge_cnt;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || wl_sel !== '0 || bl_sel !== '0 || sl_sel !== '0 ||
        wl_vsel !== 2'd3 || bl_vsel !== 2'd3 || sl_vsel !== 2'd3 || pulse_en !== 1'b0 || sa_en !== 1'b0 ||
        rsp_valid !== 1'b0 || rsp_data !== 1'b0 || rsp_fail !== 1'b0 || rsp_tries !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b wl=%h bl=%h vsel=%0d/%0d/%0d pulse=%b sa=%b rsp=%b%b%b%0d, want idle defaults",
               cmd_ready, busy, wl_sel, bl_sel, wl_vsel, bl_vsel, sl_vsel, pulse_en, sa_en,
               rsp_valid, rsp_data, rsp_fail, rsp_tries);
    end
  endtask

  task automatic test_read();
    int acc;
    logic [ROWS-1:0] ewl;
    logic [COLS-1:0] ebl;
    logic ep;
    sa_out = 1'b1;
    issue(2'd0, IW'(5), CW'(9), 1'b0, acc);
    sb.push_back('{data: 1'b1, fail: 1'b0, tries: 4'd0, due: acc + 8});
    vectors++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_ready: cmd_ready=%b, want 0", cmd_ready);
    end
    for (int k = 1; k <= 9; k++) begin
      ewl = (k <= 6) ? ROWS'(12'h020) : '0;
      ebl = (k <= 6) ? COLS'(12'h200) : '0;
      ep  = (k >= 3 && k <= 6);
      vectors++;
      if (wl_sel !== ewl || bl_sel !== ebl || sl_sel !== ebl || pulse_en !== ep || sa_en !== ep ||
          wl_vsel !== ((k <= 6) ? 2'd1 : 2'd3) || bl_vsel !== ((k <= 6) ? 2'd1 : 2'd3) || sl_vsel !== 2'd3) begin
        errors++;
        $display("FAIL read_cycle t+%0d: wl=%h bl=%h sl=%h pulse=%b sa=%b vsel=%0d/%0d/%0d, want wl=%h bl=%h pulse=%b",
                 k, wl_sel, bl_sel, sl_sel, pulse_en, sa_en, wl_vsel, bl_vsel, sl_vsel, ewl, ebl, ep);
      end
      @(negedge clk);
    end
    wait_idle();
  endtask

  task automatic test_set();
    int acc;
    int wr_cyc = 0;
    int n = 0;
    sa_out = 1'b1;
    issue(2'd1, IW'(3), CW'(4), 1'b0, acc);
    sb.push_back('{data: 1'b1, fail: 1'b0, tries: 4'd1, due: acc + 20});
    while (busy && n < 2000) begin
      if (pulse_en && !sa_en && bl_vsel == 2'd0 && wl_vsel == 2'd1 && sl_vsel == 2'd3) wr_cyc++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (wr_cyc != 8) begin
      errors++;
      $display("FAIL set_pulse_cycles: got %0d, want 8", wr_cyc);
    end
  endtask

  task automatic test_reset_op();
    int acc;
    int wr_cyc = 0;
    int wr_pulses = 0;
    int n = 0;
    logic prev = 1'b0;
    logic wr;
    sa_out = 1'b1;
    issue(2'd2, IW'(7), CW'(0), 1'b0, acc);
    sb.push_back('{data: 1'b1, fail: 1'b1, tries: 4'd4, due: acc + 80});
    while (busy && n < 2000) begin
      wr = pulse_en && !sa_en && wl_vsel == 2'd0 && bl_vsel == 2'd3 && sl_vsel == 2'd0;
      if (wr) wr_cyc++;
      if (wr && !prev) wr_pulses++;
      prev = wr;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (wr_cyc != 32 || wr_pulses != 4) begin
      errors++;
      $display("FAIL reset_pulses: got %0d pulses / %0d cycles, want 4 / 32", wr_pulses, wr_cyc);
    end
  endtask

  task automatic test_form();
    int acc;
    int wr_cyc = 0;
    int wr_pulses = 0;
    int n = 0;
    logic prev = 1'b0;
    logic wr;
    sa_out = 1'b0;
    issue(2'd3, IW'(11), CW'(11), 1'b0, acc);
    sb.push_back('{data: 1'b1, fail: 1'b0, tries: 4'd3, due: acc + 636});
    while (busy && n < 2000) begin
      wr = pulse_en && !sa_en && wl_vsel == 2'd1 && bl_vsel == 2'd0;
      if (wr) wr_cyc++;
      if (wr && !prev) wr_pulses++;
      prev = wr;
      sa_out = (wr_pulses >= 3);
      @(negedge clk);
      n++;
    end
    sa_out = 1'b1;
    vectors++;
    if (wr_cyc != 600 || wr_pulses != 3) begin
      errors++;
      $display("FAIL form_pulses: got %0d pulses / %0d cycles, want 3 / 600", wr_pulses, wr_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    sa_out = 1'b1;
    issue(2'd0, IW'(1), CW'(2), 1'b1, acc);
    sb.push_back('{data: 1'b1, fail: 1'b0, tries: 4'd0, due: acc + 8});
    sb.push_back('{data: 1'b1, fail: 1'b0, tries: 4'd0, due: acc + 18});
    sb.push_back('{data: 1'b1, fail: 1'b1, tries: 4'd0, due: acc + 20});
    while (edge_cnt != acc + 9) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: ready=%b busy=%b, want 1/0 one cycle after rsp_valid", cmd_ready, busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b ready=%b, want 1/0", busy, cmd_ready);
    end
    cmd_row = IW'(12);
    cmd_col = CW'(0);
    while (edge_cnt != acc + 19) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || pulse_en !== 1'b0) begin
      errors++;
      $display("FAIL oor_idle: ready=%b pulse=%b, want 1/0", cmd_ready, pulse_en);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b1 || pulse_en !== 1'b0 || wl_sel !== '0) begin
      errors++;
      $display("FAIL oor_resp: rsp_valid=%b pulse=%b wl=%h, want 1/0/0", rsp_valid, pulse_en, wl_sel);
    end
    wait_idle();
  endtask

  task automatic test_col_oor();
    int acc;
    issue(2'd1, IW'(0), CW'(13), 1'b0, acc);
    sb.push_back('{data: 1'b1, fail: 1'b1, tries: 4'd0, due: acc});
    vectors++;
    if (pulse_en !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL col_oor: pulse=%b rsp_valid=%b, want 0/1", pulse_en, rsp_valid);
    end
    wait_idle();
  endtask

  task automatic test_rst_mid();
    int acc;
    int n = 0;
    issue(2'd1, IW'(2), CW'(6), 1'b0, acc);
    while (!pulse_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (pulse_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pulse: pulse_en=%b, want 1 before reset", pulse_en);
    end
    wb_rst_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (wl_sel !== '0 || bl_sel !== '0 || sl_sel !== '0 || wl_vsel !== 2'd3 || bl_vsel !== 2'd3 ||
        sl_vsel !== 2'd3 || pulse_en !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: wl=%h bl=%h vsel=%0d/%0d/%0d pulse=%b ready=%b rsp_valid=%b busy=%b, want idle",
               wl_sel, bl_sel, wl_vsel, bl_vsel, sl_vsel, pulse_en, cmd_ready, rsp_valid, busy);
    end
    wb_rst_i = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_tries !== 4'd0) begin
      errors++;
      $display("FAIL rst_after: rsp_valid=%b busy=%b tries=%0d, want 0/0/0", rsp_valid, busy, rsp_tries);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_set();
    test_reset_op();
    test_form();
    test_back_to_back();
    test_col_oor();
    test_rst_mid();
    repeat (4) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
